rpn_stack_sequencer: RTL and testbench

Sequences the calculator's single-port operand stack memory (block RAM, DATA_W×2^ADDR_W) and the ALU. Pushes keypad values onto the stack and evaluates a stack frame on Enter: pops b, op and a, starts the ALU, then pushes the result back. It is the sole owner of the memory port and sits between the keypad front-end and the ALU.

---
 rtl/rpn_stack_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_rpn_stack_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_sequencer.sv
// rpn_stack_sequencer
// Owns the single port of the operand stack RAM and drives the ALU. Keypad
// pushes land on top of the stack; Enter pops b, op and (for binary ops) a,
// runs the ALU, and pushes the result back in place of the popped frame.
// Every output is a flop, so the next-state logic also computes the value
// each output must show in the state being entered.
module rpn_stack_sequencer #(
   parameter int                ADDR_W   = 13,
   parameter int                DATA_W   = 8,
   parameter int                RD_LAT   = 2,
   parameter logic [DATA_W-1:0] UNARY_OP = DATA_W'(133)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              enter_i,
   output logic              busy_o,
   output logic [ADDR_W:0]   depth_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   output logic              alu_start_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [DATA_W-1:0] alu_op_o,
   input  logic              alu_done_i,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              result_valid_o,
   output logic [DATA_W-1:0] result_o,
   output logic              err_underflow_o,
   output logic              err_overflow_o,
   output logic              err_drop_o
);

   localparam int SP_W  = ADDR_W + 1;
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [SP_W-1:0]  SP_FULL  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
   localparam logic [SP_W-1:0]  SP_TWO   = SP_W'(2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_EXEC,
      S_ALU_WAIT,
      S_WRITE_BACK
   } state_t;

   // Control state
   state_t            state_q, state_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [1:0]        k_q, k_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] op_q, op_d;

   // Output registers
   logic              busy_q, busy_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              alu_start_q, alu_start_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] alu_op_q, alu_op_d;
   logic              result_valid_q, result_valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              err_under_q, err_under_d;
   logic              err_over_q, err_over_d;
   logic              err_drop_q, err_drop_d;

   // Stack-relative addresses; the RAM address wraps naturally at 2^ADDR_W
   logic [ADDR_W-1:0] sp_lo, addr_m1, addr_m2, addr_m3;
   logic              is_unary;

   assign sp_lo    = sp_q[ADDR_W-1:0];
   assign addr_m1  = sp_lo - ADDR_W'(1);
   assign addr_m2  = sp_lo - ADDR_W'(2);
   assign addr_m3  = sp_lo - ADDR_W'(3);
   assign is_unary = (op_q == UNARY_OP);

   // Next-state and next-output logic for the sequencer FSM
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d        = state_q;
      sp_d           = sp_q;
      k_d            = k_q;
      cnt_d          = cnt_q;
      pend_d         = pend_q;
      b_d            = b_q;
      op_d           = op_q;
      mem_en_d       = 1'b0;
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_din_d      = mem_din_q;
      alu_start_d    = 1'b0;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      alu_op_d       = alu_op_q;
      result_valid_d = 1'b0;
      result_d       = result_q;
      err_under_d    = 1'b0;
      err_over_d     = 1'b0;
      // Requests arriving outside IDLE are lost; a latched enter is not one.
      err_drop_d     = (state_q != S_IDLE) && (push_valid_i || enter_i);

      unique case (state_q)
         S_IDLE: begin
            if (push_valid_i) begin
               // A simultaneous enter waits for the next IDLE cycle.
               if (enter_i) pend_d = 1'b1;
               if (sp_q == SP_FULL) begin
                  err_over_d = 1'b1;
               end else begin
                  state_d    = S_PUSH;
                  mem_en_d   = 1'b1;
                  mem_we_d   = 1'b1;
                  mem_addr_d = sp_lo;
                  mem_din_d  = push_data_i;
               end
            end else if (enter_i || pend_q) begin
               pend_d = 1'b0;
               if (sp_q < SP_TWO) begin
                  err_under_d = 1'b1;
               end else begin
                  k_d        = 2'd0;
                  state_d    = S_RD_ISSUE;
                  mem_en_d   = 1'b1;
                  mem_addr_d = addr_m1;
               end
            end
         end

         S_PUSH: begin
            sp_d    = sp_q + SP_ONE;
            state_d = S_IDLE;
         end

         S_RD_ISSUE: begin
            cnt_d   = '0;
            state_d = S_RD_WAIT;
         end

         S_RD_WAIT: begin
            if (cnt_q != CNT_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               unique case (k_q)
                  2'd0: begin
                     b_d        = mem_dout_i;
                     k_d        = 2'd1;
                     state_d    = S_RD_ISSUE;
                     mem_en_d   = 1'b1;
                     mem_addr_d = addr_m2;
                  end
                  2'd1: begin
                     op_d = mem_dout_i;
                     if (mem_dout_i == UNARY_OP) begin
                        state_d     = S_EXEC;
                        alu_start_d = 1'b1;
                        alu_a_d     = '0;
                        alu_b_d     = b_q;
                        alu_op_d    = mem_dout_i;
                     end else if (sp_q == SP_TWO) begin
                        // Only reads have happened, so the stack is intact.
                        err_under_d = 1'b1;
                        state_d     = S_IDLE;
                     end else begin
                        k_d        = 2'd2;
                        state_d    = S_RD_ISSUE;
                        mem_en_d   = 1'b1;
                        mem_addr_d = addr_m3;
                     end
                  end
                  default: begin
                     state_d     = S_EXEC;
                     alu_start_d = 1'b1;
                     alu_a_d     = mem_dout_i;
                     alu_b_d     = b_q;
                     alu_op_d    = op_q;
                  end
               endcase
            end
         end

         S_EXEC: begin
            state_d = S_ALU_WAIT;
         end

         S_ALU_WAIT: begin
            if (alu_done_i) begin
               state_d        = S_WRITE_BACK;
               mem_en_d       = 1'b1;
               mem_we_d       = 1'b1;
               mem_addr_d     = is_unary ? addr_m2 : addr_m3;
               mem_din_d      = alu_result_i;
               result_valid_d = 1'b1;
               result_d       = alu_result_i;
            end
         end

         S_WRITE_BACK: begin
            // Frame of n entries collapses to the single result: sp - n + 1.
            sp_d    = is_unary ? (sp_q - SP_ONE) : (sp_q - SP_TWO);
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Control registers; reset empties the stack logically via sp
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the stack RAM lives outside and is never cleared; sp=0 alone
      // makes its old contents unreachable, so only pointers and flags reset.
      if (!rst) begin
         state_q <= S_IDLE;
         sp_q    <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q <= state_d;
         sp_q    <= sp_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

   // Output registers, loaded with the values for the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q         <= 1'b0;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         alu_start_q    <= 1'b0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         result_valid_q <= 1'b0;
         result_q       <= '0;
         err_under_q    <= 1'b0;
         err_over_q     <= 1'b0;
         err_drop_q     <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         mem_en_q       <= mem_en_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_din_q      <= mem_din_d;
         alu_start_q    <= alu_start_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         result_valid_q <= result_valid_d;
         result_q       <= result_d;
         err_under_q    <= err_under_d;
         err_over_q     <= err_over_d;
         err_drop_q     <= err_drop_d;
      end
   end

   assign busy_o          = busy_q;
   assign depth_o         = sp_q;
   assign mem_en_o        = mem_en_q;
   assign mem_we_o        = mem_we_q;
   assign mem_addr_o      = mem_addr_q;
   assign mem_din_o       = mem_din_q;
   assign alu_start_o     = alu_start_q;
   assign alu_a_o         = alu_a_q;
   assign alu_b_o         = alu_b_q;
   assign alu_op_o        = alu_op_q;
   assign result_valid_o  = result_valid_q;
   assign result_o        = result_q;
   assign err_underflow_o = err_under_q;
   assign err_overflow_o  = err_over_q;
   assign err_drop_o      = err_drop_q;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Scoreboard bench for rpn_stack_sequencer: stimulus queues the expected
// memory traffic, ALU starts, results and error pulses; a monitor on the
// falling edge pops and compares whenever the DUT presents one of them.
module tb_rpn_stack_sequencer;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   localparam logic [2:0] M_UNDER = 3'b001;
   localparam logic [2:0] M_OVER  = 3'b010;
   localparam logic [2:0] M_DROP  = 3'b100;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_exp_t;

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] op;
      logic [DATA_W-1:0] res;
      int                cyc;
   } alu_exp_t;

   typedef struct {
      logic [2:0] mask;
      int         cyc;
   } err_exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              push_valid = 1'b0;
   logic [DATA_W-1:0] push_data = '0;
   logic              enter = 1'b0;
   logic              busy;
   logic [ADDR_W:0]   depth;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic              alu_start;
   logic [DATA_W-1:0] alu_a, alu_b, alu_op;
   logic              alu_done = 1'b0;
   logic [DATA_W-1:0] alu_result = '0;
   logic              result_valid;
   logic [DATA_W-1:0] result;
   logic              err_underflow, err_overflow, err_drop;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_at = -10;
   logic [DATA_W-1:0] done_res = '0;

   wr_exp_t           wr_q[$];
   logic [ADDR_W-1:0] rd_q[$];
   alu_exp_t          alu_q[$];
   logic [DATA_W-1:0] res_q[$];
   err_exp_t          err_q[$];

   rpn_stack_sequencer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RD_LAT  (RD_LAT),
      .UNARY_OP(8'h85)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .push_valid_i   (push_valid),
      .push_data_i    (push_data),
      .enter_i        (enter),
      .busy_o         (busy),
      .depth_o        (depth),
      .mem_en_o       (mem_en),
      .mem_we_o       (mem_we),
      .mem_addr_o     (mem_addr),
      .mem_din_o      (mem_din),
      .mem_dout_i     (mem_dout),
      .alu_start_o    (alu_start),
      .alu_a_o        (alu_a),
      .alu_b_o        (alu_b),
      .alu_op_o       (alu_op),
      .alu_done_i     (alu_done),
      .alu_result_i   (alu_result),
      .result_valid_o (result_valid),
      .result_o       (result),
      .err_underflow_o(err_underflow),
      .err_overflow_o (err_overflow),
      .err_drop_o     (err_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stack RAM model with RD_LAT cycles of read latency
   logic [DATA_W-1:0] mem [4];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   initial for (int i = 0; i < 4; i++) mem[i] = '0;

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_din;
      if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign mem_dout = rd_pipe[RD_LAT-1];

   // ALU model: answers two cycles after start with the scoreboard's result
   always @(posedge clk) begin
      #1;
      if (cyc == done_at) begin
         alu_done   = 1'b1;
         alu_result = done_res;
      end else begin
         alu_done   = 1'b0;
         alu_result = '0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
   endtask

   // Monitor: every DUT output event is popped from its queue and compared
   always @(negedge clk) begin
      if (mem_en && mem_we) begin
         if (wr_q.size() == 0) unexpected("mem_write");
         else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.addr));
            check("wr_data", 32'(mem_din), 32'(w.data));
         end
      end
      if (mem_en && !mem_we) begin
         if (rd_q.size() == 0) unexpected("mem_read");
         else check("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
      end
      if (alu_start) begin
         if (alu_q.size() == 0) begin
            unexpected("alu_start");
            done_at  = cyc + 2;
            done_res = '0;
         end else begin
            alu_exp_t e;
            e = alu_q.pop_front();
            check("alu_a", 32'(alu_a), 32'(e.a));
            check("alu_b", 32'(alu_b), 32'(e.b));
            check("alu_op", 32'(alu_op), 32'(e.op));
            check("alu_start_cycle", cyc, e.cyc);
            done_at  = cyc + 2;
            done_res = e.res;
         end
      end
      if (result_valid) begin
         if (res_q.size() == 0) unexpected("result_valid");
         else begin
            check("result", 32'(result), 32'(res_q.pop_front()));
            check("result_cycle", cyc, done_at + 1);
         end
      end
      if (err_underflow || err_overflow || err_drop) begin
         if (err_q.size() == 0) unexpected("err_pulse");
         else begin
            err_exp_t e;
            e = err_q.pop_front();
            check("err_flags", 32'({err_drop, err_overflow, err_underflow}), 32'(e.mask));
            check("err_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_exp_t w;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
   endtask

   task automatic exp_alu(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [DATA_W-1:0] op, input logic [DATA_W-1:0] res,
                          input int at);
      alu_exp_t e;
      e.a = a; e.b = b; e.op = op; e.res = res; e.cyc = at;
      alu_q.push_back(e);
   endtask

   task automatic exp_err(input logic [2:0] mask, input int at);
      err_exp_t e;
      e.mask = mask;
      e.cyc  = at;
      err_q.push_back(e);
   endtask

   task automatic do_push(input logic [DATA_W-1:0] v);
      push_valid = 1'b1;
      push_data  = v;
      tick();
      push_valid = 1'b0;
      tick();
   endtask

   task automatic do_enter();
      enter = 1'b1;
      tick();
      enter = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_depth"}, 32'(depth), 0);
      check({tag, "_mem_en"}, 32'(mem_en), 0);
      check({tag, "_mem_we"}, 32'(mem_we), 0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check({tag, "_mem_din"}, 32'(mem_din), 0);
      check({tag, "_alu_start"}, 32'(alu_start), 0);
      check({tag, "_alu_abop"}, 32'({alu_a, alu_b, alu_op}), 0);
      check({tag, "_result_valid"}, 32'(result_valid), 0);
      check({tag, "_result"}, 32'(result), 0);
      check({tag, "_errs"}, 32'({err_underflow, err_overflow, err_drop}), 0);
   endtask

   initial begin
      wait_cycles(3);
      check_all_zero("reset");
      rst = 1'b1;
      wait_cycles(2);

      // Binary op: 5 + 3 with op 0x2B
      exp_wr(0, 8'h05); do_push(8'h05);
      exp_wr(1, 8'h2B); do_push(8'h2B);
      exp_wr(2, 8'h03); do_push(8'h03);
      check("depth_after_3_push", 32'(depth), 3);
      exp_rd(2); exp_rd(1); exp_rd(0);
      exp_alu(8'h05, 8'h03, 8'h2B, 8'h08, cyc + 10);
      exp_wr(0, 8'h08);
      res_q.push_back(8'h08);
      do_enter();
      wait_cycles(20);
      check("depth_after_binary", 32'(depth), 1);
      check("busy_after_binary", 32'(busy), 0);

      // Unary op 0x85 on b=7 over a stack holding {8}
      exp_wr(1, 8'h85); do_push(8'h85);
      exp_wr(2, 8'h07); do_push(8'h07);
      exp_rd(2); exp_rd(1);
      exp_alu(8'h00, 8'h07, 8'h85, 8'hF8, cyc + 7);
      exp_wr(1, 8'hF8);
      res_q.push_back(8'hF8);
      do_enter();
      wait_cycles(16);
      check("depth_after_unary", 32'(depth), 2);
      check("result_held", 32'(result), 32'(8'hF8));

      // Stack {8, F8}: op 0x08 is binary but there is no a -> underflow
      exp_rd(1); exp_rd(0);
      exp_err(M_UNDER, cyc + 7);
      do_enter();
      wait_cycles(12);
      check("depth_after_underflow2", 32'(depth), 2);

      // Fill to capacity, then one more push overflows
      exp_wr(2, 8'h2D); do_push(8'h2D);
      exp_wr(3, 8'h02); do_push(8'h02);
      check("depth_full", 32'(depth), 4);
      exp_err(M_OVER, cyc + 1);
      do_push(8'h09);
      check("depth_after_overflow", 32'(depth), 4);

      // F8 - 2 with a push dropped during ALU_WAIT
      exp_rd(3); exp_rd(2); exp_rd(1);
      exp_alu(8'hF8, 8'h02, 8'h2D, 8'hF6, cyc + 10);
      exp_err(M_DROP, cyc + 12);
      exp_wr(1, 8'hF6);
      res_q.push_back(8'hF6);
      do_enter();
      wait_cycles(10);
      push_valid = 1'b1;
      push_data  = 8'h55;
      tick();
      push_valid = 1'b0;
      wait_cycles(15);
      check("depth_after_drop", 32'(depth), 2);

      // Push and enter together: push first, evaluation one IDLE later
      exp_wr(2, 8'h2B); do_push(8'h2B);
      exp_wr(3, 8'h04);
      exp_rd(3); exp_rd(2); exp_rd(1);
      exp_alu(8'hF6, 8'h04, 8'h2B, 8'hFA, cyc + 12);
      exp_wr(1, 8'hFA);
      res_q.push_back(8'hFA);
      push_valid = 1'b1;
      push_data  = 8'h04;
      enter      = 1'b1;
      tick();
      push_valid = 1'b0;
      enter      = 1'b0;
      wait_cycles(22);
      check("depth_after_collision", 32'(depth), 2);

      // Reset in RD_WAIT aborts everything at once
      exp_rd(1);
      do_enter();
      tick();
      rst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      rst = 1'b1;
      tick();
      check("depth_after_reset", 32'(depth), 0);
      exp_err(M_UNDER, cyc + 1);
      do_enter();
      wait_cycles(4);

      // Single entry: enter underflows without touching memory
      exp_wr(0, 8'h11); do_push(8'h11);
      check("depth_one", 32'(depth), 1);
      exp_err(M_UNDER, cyc + 1);
      do_enter();
      wait_cycles(4);
      check("depth_after_underflow1", 32'(depth), 1);

      check("left_writes", wr_q.size(), 0);
      check("left_reads", rd_q.size(), 0);
      check("left_alu", alu_q.size(), 0);
      check("left_results", res_q.size(), 0);
      check("left_errors", err_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   task automatic exp_rd(input logic [ADDR_W-1:0] a);
      rd_q.push_back(a);
   endtask

endmodule
